bin_2s_com: RTL and testbench

- Registered two's-complement negator: out = (~in + 1) mod 2^WIDTH, i.e. the arithmetic negation of the input bit pattern.
- Sits on a datapath as a single-stage pipeline element with a valid qualifier.
- Also flags the one input that has no representable negation (most-negative value).
- Default width 4; the output is interpreted as a signed value downstream.

---
 rtl/bin_2s_com.sv | 96 +++++++++
 tb/tb_bin_2s_com.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bin_2s_com.sv
// -----------------------------------------------------------------------------
// bin_2s_com
//
// Registered two's-complement negator. Each accepted input is replaced by its
// arithmetic negation, out = (~in + 1) mod 2^WIDTH, and the result appears
// exactly one clock later. The block accepts one input per cycle.
//
// The single input with no representable negation is the most-negative
// pattern (1 followed by WIDTH-1 zeros). It is flagged on ovf. An all-zero
// input is flagged on zero.
//
// Optional build macro:
//   BIN_2S_COM_SAT_EN  when defined, a most-negative input produces the
//                      largest positive value {1'b0, {WIDTH-1{1'b1}}}
//                      instead of wrapping back to itself. ovf is still set.
//                      When undefined, no saturation logic is built.
//
// Parameters:
//   WIDTH      data width of in/out, legal range 2..64 (default 4)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, has priority over in_valid
//   in_valid   qualifies in on the rising edge of clk
//   in         operand, WIDTH bits
//   out_valid  out/ovf/zero were computed from an input accepted last cycle
//   out        negation of the last accepted in (signed interpretation)
//   ovf        last accepted in was the most-negative pattern
//   zero       last accepted in was all zeros
//
// Every output comes straight from a register. No combinational path runs
// from in or in_valid to any output.
// -----------------------------------------------------------------------------
module bin_2s_com #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] neg;
    logic [WIDTH-1:0] result;
    logic             is_most_neg;
    logic             is_zero;

    // The sum is WIDTH bits wide, so the carry out of the +1 is dropped.
    // That gives modular negation: 0 maps to 0, and MOST_NEG maps to itself.
    always_comb begin
        neg         = ~in + ONE;
        is_most_neg = (in == MOST_NEG);
        is_zero     = (in == '0);
    end

`ifdef BIN_2S_COM_SAT_EN
    // The negation of MOST_NEG is out of range, so clamp it to the largest
    // positive value (~MOST_NEG = 0 followed by all ones).
    always_comb begin
        result = neg;
        if (is_most_neg) begin
            result = ~MOST_NEG;
        end
    end
`else
    always_comb begin
        result = neg;
    end
`endif

    // out, ovf and zero load only when an input is accepted. On idle cycles
    // they keep the last result, and out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= result;
                ovf  <= is_most_neg;
                zero <= is_zero;
            end
        end
    end

endmodule

// File: tb/tb_bin_2s_com.sv
module tb_bin_2s_com;

    logic       clk = 1'b0;
    logic       rst;
    logic       v4, v8;
    logic [3:0] in4;
    logic [7:0] in8;
    logic       ov4, ov8, of4, of8, z4, z8;
    logic [3:0] out4;
    logic [7:0] out8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bin_2s_com #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in(in4),
        .out_valid(ov4), .out(out4), .ovf(of4), .zero(z4)
    );

    bin_2s_com #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in(in8),
        .out_valid(ov8), .out(out8), .ovf(of8), .zero(z8)
    );

    typedef struct {
        logic [3:0] din;
        logic [3:0] dout;
        logic       dovf;
        logic       dzero;
    } vec_t;

    vec_t vecs[16];

    // Reference model: negation taken as (2^w - v) mod 2^w on plain integers.
    function automatic longint ref_neg(int w, longint v);
        longint m = longint'(1) << w;
        longint r = (m - v) % m;
`ifdef BIN_2S_COM_SAT_EN
        if (v == (m >> 1)) r = (m >> 1) - 1;
`endif
        return r;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    longint m_out4, m_out8;
    logic   m_v4, m_v8, m_f4, m_f8, m_z4, m_z8;
    logic [3:0] sat8_4, x4, r4;

    initial begin
`ifdef BIN_2S_COM_SAT_EN
        sat8_4 = 4'h7;
`else
        sat8_4 = 4'h8;
`endif
        vecs[0]  = '{4'h0, 4'h0, 1'b0, 1'b1};
        vecs[1]  = '{4'h1, 4'hF, 1'b0, 1'b0};
        vecs[2]  = '{4'h2, 4'hE, 1'b0, 1'b0};
        vecs[3]  = '{4'h3, 4'hD, 1'b0, 1'b0};
        vecs[4]  = '{4'h4, 4'hC, 1'b0, 1'b0};
        vecs[5]  = '{4'h5, 4'hB, 1'b0, 1'b0};
        vecs[6]  = '{4'h6, 4'hA, 1'b0, 1'b0};
        vecs[7]  = '{4'h7, 4'h9, 1'b0, 1'b0};
        vecs[8]  = '{4'h8, sat8_4, 1'b1, 1'b0};
        vecs[9]  = '{4'h9, 4'h7, 1'b0, 1'b0};
        vecs[10] = '{4'hA, 4'h6, 1'b0, 1'b0};
        vecs[11] = '{4'hB, 4'h5, 1'b0, 1'b0};
        vecs[12] = '{4'hC, 4'h4, 1'b0, 1'b0};
        vecs[13] = '{4'hD, 4'h3, 1'b0, 1'b0};
        vecs[14] = '{4'hE, 4'h2, 1'b0, 1'b0};
        vecs[15] = '{4'hF, 4'h1, 1'b0, 1'b0};

        // Reset held for 2 cycles while an input is offered; the input must be ignored.
        rst = 1'b1; v4 = 1'b1; in4 = 4'd5; v8 = 1'b0; in8 = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out", out4, 0);
            chk("rst_valid", ov4, 0);
            chk("rst_ovf", of4, 0);
            chk("rst_zero", z4, 0);
            chk("rst_valid8", ov8, 0);
        end
        rst = 1'b0;
        chk("post_rst_no_early", ov4, 0);
        tick();
        chk("first_valid", ov4, 1);
        chk("first_out", out4, 4'hB);

        // Back-to-back sweep over all 16 inputs.
        for (int i = 0; i < 16; i++) begin
            in4 = vecs[i].din; v4 = 1'b1;
            tick();
            chk($sformatf("sweep_out[%0d]", i), out4, vecs[i].dout);
            chk($sformatf("sweep_ovf[%0d]", i), of4, vecs[i].dovf);
            chk($sformatf("sweep_zero[%0d]", i), z4, vecs[i].dzero);
            chk($sformatf("sweep_valid[%0d]", i), ov4, 1);
        end

        // Hold: accept 6, then idle for 3 cycles with in changing.
        in4 = 4'd6; v4 = 1'b1;
        tick();
        chk("hold_accept", out4, 4'hA);
        v4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in4 = 4'($urandom_range(0, 15));
            tick();
            chk("hold_out", out4, 4'hA);
            chk("hold_valid", ov4, 0);
            chk("hold_ovf", of4, 0);
            chk("hold_zero", z4, 0);
        end

        // Involution: feeding the result back in returns the original value.
        for (int i = 0; i < 4; i++) begin
            r4 = 4'($urandom_range(0, 15));
            if (r4 == 4'h8) r4 = 4'h3;
            in4 = r4; v4 = 1'b1;
            tick();
            x4 = out4;
            in4 = x4;
            tick();
            chk("involution", out4, r4);
        end
        v4 = 1'b0;

        // WIDTH=8 instance boundaries.
        in8 = 8'h80; v8 = 1'b1;
        tick();
        chk("w8_ovf", of8, 1);
        chk("w8_mostneg_out", out8, ref_neg(8, 8'h80));
        in8 = 8'h01;
        tick();
        chk("w8_one_out", out8, 8'hFF);
        chk("w8_one_ovf", of8, 0);
        in8 = 8'h00;
        tick();
        chk("w8_zero", z8, 1);
        chk("w8_zero_out", out8, 0);

        // Random stimulus against the reference model on both widths.
        m_v4 = ov4; m_out4 = out4; m_f4 = of4; m_z4 = z4;
        m_v8 = ov8; m_out8 = out8; m_f8 = of8; m_z8 = z8;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            v4  = $urandom_range(0, 3) != 0;
            v8  = $urandom_range(0, 3) != 0;
            in4 = 4'($urandom);
            in8 = 8'($urandom);
            if (rst) begin
                m_v4 = 0; m_out4 = 0; m_f4 = 0; m_z4 = 0;
                m_v8 = 0; m_out8 = 0; m_f8 = 0; m_z8 = 0;
            end else begin
                m_v4 = v4;
                if (v4) begin
                    m_out4 = ref_neg(4, in4); m_f4 = (in4 == 8); m_z4 = (in4 == 0);
                end
                m_v8 = v8;
                if (v8) begin
                    m_out8 = ref_neg(8, in8); m_f8 = (in8 == 128); m_z8 = (in8 == 0);
                end
            end
            tick();
            chk("rnd4_valid", ov4, m_v4);
            chk("rnd4_out", out4, m_out4);
            chk("rnd4_ovf", of4, m_f4);
            chk("rnd4_zero", z4, m_z4);
            chk("rnd8_valid", ov8, m_v8);
            chk("rnd8_out", out8, m_out8);
            chk("rnd8_ovf", of8, m_f8);
            chk("rnd8_zero", z8, m_z8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
